// File: rtl/spi_mem_ctrl_pkg.sv
// spi_ctrl_pkg: shared command/FSM types for the SPI memory controller and the SPI slave
// Contents: CTRL_WIDTH (command field width), cmd_t (frame commands), ctrl_state_t (controller FSM states)
package spi_ctrl_pkg;

    localparam int CTRL_WIDTH = 2;

    typedef enum logic [CTRL_WIDTH-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        MEM_WR,
        MEM_RD,
        RD_WAIT,
        TX
    } ctrl_state_t;

endpackage

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: decodes SPI frames into address/data commands and sequences a single-port synchronous memory
// Ports: clk, rst (async, active-high); rx_valid/rx_data frame input from the SPI slave;
//        tx_valid/tx_data read data back to the slave for FRAME_WIDTH cycles;
//        mem_en/mem_we/mem_addr/mem_wdata/mem_rdata memory port; busy (not IDLE); cmd_err error pulse
module spi_mem_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int FRAME_WIDTH = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_LATENCY = 1,
    parameter int AUTO_INC    = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx_valid,
    input  logic [FRAME_WIDTH+CTRL_WIDTH-1:0] rx_data,
    output logic                              tx_valid,
    output logic [FRAME_WIDTH-1:0]            tx_data,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [FRAME_WIDTH-1:0]            mem_wdata,
    input  logic [FRAME_WIDTH-1:0]            mem_rdata,
    output logic                              busy,
    output logic                              cmd_err
);

    localparam int CW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

    if (MEM_LATENCY != 1 && MEM_LATENCY != 2) begin : g_bad_latency
        $error("spi_mem_ctrl: MEM_LATENCY must be 1 or 2");
    end

    ctrl_state_t            state, next_state;
    cmd_t                   cmd;
    logic [FRAME_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0]  wr_addr, rd_addr;
    logic                   rd_armed;
    logic                   rx_valid_q;
    logic                   lat_cnt;
    logic [CW-1:0]          tx_cnt;
    logic                   new_frame;
    logic                   lat_done;

    assign new_frame = rx_valid & ~rx_valid_q;
    assign lat_done  = lat_cnt == 1'(MEM_LATENCY - 1);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = new_frame ? DECODE : IDLE;
            DECODE:  next_state = (cmd == CMD_WR_DATA) ? MEM_WR :
                                  (cmd == CMD_RD_DATA && rd_armed) ? MEM_RD : IDLE;
            MEM_WR:  next_state = IDLE;
            MEM_RD:  next_state = RD_WAIT;
            RD_WAIT: next_state = lat_done ? TX : RD_WAIT;
            TX:      next_state = (tx_cnt == '0) ? IDLE : TX;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so the strobes line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cmd        <= CMD_WR_ADDR;
            payload    <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_armed   <= 1'b0;
            rx_valid_q <= 1'b0;
            lat_cnt    <= 1'b0;
            tx_cnt     <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= next_state;
            rx_valid_q <= rx_valid;
            busy       <= next_state != IDLE;
            mem_en     <= next_state == MEM_WR || next_state == MEM_RD;
            mem_we     <= next_state == MEM_WR;
            // A frame arriving while busy is dropped; so is a read with no armed address.
            cmd_err    <= (new_frame && state != IDLE) ||
                          (state == DECODE && cmd == CMD_RD_DATA && !rd_armed);
            lat_cnt    <= (state == RD_WAIT) ? lat_cnt + 1'b1 : 1'b0;
            if (state == IDLE && new_frame) begin
                cmd     <= cmd_t'(rx_data[FRAME_WIDTH+CTRL_WIDTH-1:FRAME_WIDTH]);
                payload <= rx_data[FRAME_WIDTH-1:0];
            end
            if (state == DECODE && cmd == CMD_WR_ADDR) wr_addr <= payload[ADDR_WIDTH-1:0];
            if (state == DECODE && cmd == CMD_RD_ADDR) begin
                rd_addr  <= payload[ADDR_WIDTH-1:0];
                rd_armed <= 1'b1;
            end
            if (next_state == MEM_WR) begin
                mem_addr  <= wr_addr;
                mem_wdata <= payload;
            end
            if (next_state == MEM_RD) mem_addr <= rd_addr;
            if (state == MEM_WR && AUTO_INC != 0) wr_addr <= wr_addr + 1'b1;
            if (state == RD_WAIT && lat_done) begin
                tx_data  <= mem_rdata;
                tx_valid <= 1'b1;
                tx_cnt   <= CW'(FRAME_WIDTH - 1);
                rd_armed <= 1'b0;
                if (AUTO_INC != 0) rd_addr <= rd_addr + 1'b1;
            end
            if (state == TX) begin
                tx_cnt <= tx_cnt - 1'b1;
                if (tx_cnt == '0) tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: scoreboard bench for spi_mem_ctrl over three configurations
// Instances: 0 = latency 1, 1 = latency 2, 2 = latency 1 with auto-increment
module tb_spi_mem_ctrl;

    localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_TX = 2'd2, K_ERR = 2'd3;

    typedef struct packed {
        logic [1:0] i;
        logic [1:0] k;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid  [3];
    logic [9:0] rx_data   [3];
    logic       tx_valid  [3];
    logic [7:0] tx_data   [3];
    logic       mem_en    [3];
    logic       mem_we    [3];
    logic [7:0] mem_addr  [3];
    logic [7:0] mem_wdata [3];
    logic [7:0] mem_rdata [3];
    logic       busy      [3];
    logic       cmd_err   [3];

    ev_t        sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         run [3];
    int         rd_cyc [3];
    bit         tvq [3];
    bit         stable [3];
    logic [7:0] d0 [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int LAT = (g == 1) ? 2 : 1;
        logic [7:0] mem [256];
        logic [7:0] r1 = 8'h00;
        logic [7:0] r2 = 8'h00;
        initial begin
            mem[8'h12] = 8'h3C;
            mem[8'h20] = 8'hC3;
            mem[8'h40] = 8'h77;
        end
        always @(posedge clk) begin
            if (mem_en[g]) begin
                if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
                else r1 <= mem[mem_addr[g]];
            end
            r2 <= r1;
        end
        assign mem_rdata[g] = (LAT == 1) ? r1 : r2;
        spi_mem_ctrl #(
            .FRAME_WIDTH(8),
            .ADDR_WIDTH(8),
            .MEM_LATENCY(LAT),
            .AUTO_INC((g == 2) ? 1 : 0)
        ) dut (
            .clk(clk),
            .rst(rst),
            .rx_valid(rx_valid[g]),
            .rx_data(rx_data[g]),
            .tx_valid(tx_valid[g]),
            .tx_data(tx_data[g]),
            .mem_en(mem_en[g]),
            .mem_we(mem_we[g]),
            .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .busy(busy[g]),
            .cmd_err(cmd_err[g])
        );
    end

    task automatic push(input int i, input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
        sb.push_back({2'(i), k, a, b});
    endtask

    task automatic expect_ev(input int i, input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event inst=%0d kind=%0d a=%h b=%h, required none", i, k, a, b);
        end else begin
            e = sb.pop_front();
            if (e != {2'(i), k, a, b}) begin
                miscompares++;
                $display("FAIL event inst=%0d kind=%0d a=%h b=%h, required inst=%0d kind=%0d a=%h b=%h",
                         i, k, a, b, e.i, e.k, e.a, e.b);
            end
        end
    endtask

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h, required %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                run[i] = 0;
                tvq[i] = 1'b0;
            end else begin
                if (mem_en[i]) expect_ev(i, mem_we[i] ? K_WR : K_RD, mem_addr[i], mem_we[i] ? mem_wdata[i] : 8'h00);
                if (cmd_err[i]) expect_ev(i, K_ERR, 8'h00, 8'h00);
                if (tx_valid[i] && !tvq[i]) begin
                    d0[i] = tx_data[i];
                    stable[i] = 1'b1;
                    run[i] = 0;
                    check("tx_latency", 64'(cyc - rd_cyc[i]), 64'(((i == 1) ? 2 : 1) + 1));
                end
                if (tx_valid[i]) begin
                    run[i]++;
                    if (tx_data[i] != d0[i]) stable[i] = 1'b0;
                end
                if (!tx_valid[i] && tvq[i]) expect_ev(i, K_TX, d0[i], stable[i] ? 8'(run[i]) : 8'h00);
                tvq[i] = tx_valid[i];
                if (mem_en[i] && !mem_we[i]) rd_cyc[i] = cyc;
            end
        end
    end

    task automatic frame(input int i, input logic [1:0] c, input logic [7:0] p, input int hold);
        @(negedge clk);
        rx_data[i] = {c, p};
        rx_valid[i] = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(busy[i]), 64'd0);
    endtask

    task automatic wait_tx(input int i);
        int n = 0;
        while (!tx_valid[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tx_timeout", 64'(tx_valid[i]), 64'd1);
    endtask

    task automatic send(input int i, input logic [1:0] c, input logic [7:0] p, input int hold);
        frame(i, c, p, hold);
        wait_idle(i);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_valid[i] = 1'b0;
            rx_data[i] = 10'h000;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check("reset_outputs", 64'({tx_valid[i], busy[i], mem_en[i], mem_we[i], cmd_err[i],
                                       tx_data[i], mem_addr[i], mem_wdata[i]}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        push(0, K_ERR, 8'h00, 8'h00);
        send(0, 2'b11, 8'h00, 1);

        push(0, K_RD, 8'h12, 8'h00);
        push(0, K_TX, 8'h3C, 8'd8);
        send(0, 2'b10, 8'h12, 1);
        send(0, 2'b11, 8'h00, 3);

        push(0, K_ERR, 8'h00, 8'h00);
        send(0, 2'b11, 8'h00, 1);

        push(0, K_WR, 8'h12, 8'hA5);
        send(0, 2'b00, 8'h12, 1);
        send(0, 2'b01, 8'hA5, 1);

        push(0, K_WR, 8'h12, 8'h5A);
        send(0, 2'b01, 8'h5A, 50);

        push(0, K_RD, 8'h20, 8'h00);
        push(0, K_ERR, 8'h00, 8'h00);
        push(0, K_TX, 8'hC3, 8'd8);
        send(0, 2'b10, 8'h20, 1);
        frame(0, 2'b11, 8'h00, 1);
        wait_tx(0);
        repeat (2) @(negedge clk);
        frame(0, 2'b00, 8'h99, 2);
        wait_idle(0);
        push(0, K_WR, 8'h12, 8'h66);
        send(0, 2'b01, 8'h66, 1);

        push(1, K_RD, 8'h12, 8'h00);
        push(1, K_TX, 8'h3C, 8'd8);
        send(1, 2'b10, 8'h12, 1);
        send(1, 2'b11, 8'h00, 1);

        push(2, K_WR, 8'hFF, 8'h11);
        push(2, K_WR, 8'h00, 8'h22);
        send(2, 2'b00, 8'hFF, 1);
        send(2, 2'b01, 8'h11, 1);
        send(2, 2'b01, 8'h22, 1);

        push(0, K_RD, 8'h40, 8'h00);
        send(0, 2'b10, 8'h40, 1);
        frame(0, 2'b11, 8'h00, 1);
        wait_tx(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_tx_valid", 64'(tx_valid[0]), 64'd0);
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_tx_data", 64'(tx_data[0]), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(0, K_ERR, 8'h00, 8'h00);
        send(0, 2'b11, 8'h00, 1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
Command controller that sits between the SPI slave's parallel frame interface and a single-port synchronous memory. It decodes each received (FRAME_WIDTH+2)-bit frame into one of four commands: write address, write data, read address or read data. It sequences the memory strobes and, for reads, drives tx_data/tx_valid back to the slave for exactly one frame time. Only one command is in flight at a time.

Parameters:
FRAME_WIDTH, 8, payload width; also the memory data width.
ADDR_WIDTH, 8, memory address width; must be <= FRAME_WIDTH; address = payload[ADDR_WIDTH-1:0].
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal values 1 or 2; any other value is an elaboration error.
AUTO_INC, 0, if 1, wr_addr/rd_addr post-increment after each data access, wrapping modulo 2^ADDR_WIDTH.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
rx_valid  in  1  from SPI slave; level, stays high until SS_n deasserts.
rx_data  in  FRAME_WIDTH+2  frame; [FRAME_WIDTH+1:FRAME_WIDTH] = command, [FRAME_WIDTH-1:0] = payload.
tx_valid  out  1  to SPI slave; high for exactly FRAME_WIDTH cycles per read.
tx_data  out  FRAME_WIDTH  read data to SPI slave; stable while tx_valid is high.
mem_en  out  1  memory access strobe, one cycle.
mem_we  out  1  write enable, qualified by mem_en.
mem_addr  out  ADDR_WIDTH  memory address.
mem_wdata  out  FRAME_WIDTH  write data.
mem_rdata  in  FRAME_WIDTH  read data, valid MEM_LATENCY cycles after mem_en.
busy  out  1  high in every state except IDLE.
cmd_err  out  1  one-cycle pulse on an illegal or dropped command.

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high. While rst is high, all outputs are 0, wr_addr=rd_addr=0, rd_armed=0, state=IDLE. Assertion mid-operation aborts immediately and tx_valid drops in the same cycle.
- All outputs are registered.
- Frame detect: new_frame = rx_valid & ~rx_valid_q, where rx_valid_q is the registered copy of rx_valid. A level-held rx_valid is never re-decoded.
- Commands: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- FSM states: IDLE, DECODE, MEM_WR, MEM_RD, RD_WAIT, TX.
  - IDLE: on new_frame, latch the command and payload, go to DECODE.
  - DECODE:
    - WR_ADDR: wr_addr <= payload, go to IDLE.
    - RD_ADDR: rd_addr <= payload, rd_armed <= 1, go to IDLE.
    - WR_DATA: go to MEM_WR.
    - RD_DATA with rd_armed=1: go to MEM_RD.
    - RD_DATA with rd_armed=0: cmd_err pulse, go to IDLE.
  - MEM_WR: mem_en=mem_we=1, mem_addr=wr_addr, mem_wdata=payload for exactly one cycle. Apply AUTO_INC, then go to IDLE.
  - MEM_RD: mem_en=1, mem_we=0, mem_addr=rd_addr for one cycle, go to RD_WAIT.
  - RD_WAIT: wait MEM_LATENCY cycles, then capture tx_data <= mem_rdata. rd_armed <= 0, apply AUTO_INC to rd_addr, go to TX.
  - TX: tx_valid=1, a down-counter runs FRAME_WIDTH cycles. At terminal count, tx_valid <= 0 and go to IDLE.
- tx_data holds its value after TX until the next read load.
- Latency:
  - Write: mem_en is high during the 2nd cycle after rx_valid is first sampled high.
  - Read: mem_en at the same point. tx_valid rises MEM_LATENCY+1 cycles after the mem_en cycle.
- mem_addr and mem_wdata hold their last values when mem_en=0. mem_we=0 whenever mem_en=0.
- new_frame while busy=1: frame dropped, cmd_err pulse, state unaffected.
- Address wrap: increment from 2^ADDR_WIDTH-1 gives 0.

Decomposition:
- Package spi_ctrl_pkg holds:
  - CTRL_WIDTH=2.
  - cmd_t enum {CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11}.
  - ctrl_state_t enum for the FSM states.
- The SPI slave is to import CTRL_WIDTH from the package as well.
- No sub-module: edge detect, FSM and counters all fit in one module.

Test Plan:
- Frame 00_0x12, then frame 01_0xA5 -> one mem_en&mem_we cycle with mem_addr=0x12, mem_wdata=0xA5. No tx_valid, cmd_err=0.
- Frame 10_0x12, then 11_0x00, memory model returns 0x3C with MEM_LATENCY=1 (repeat with 2) -> mem_en read at 0x12; tx_data=0x3C; tx_valid high exactly 8 cycles, starting 2 (resp. 3) cycles after mem_en.
- Frame 11_0x00 with no prior RD_ADDR -> cmd_err single pulse, no mem_en, tx_valid stays 0. A second 11 right after a completed read also pulses cmd_err.
- rx_valid held high for 50 cycles -> exactly one decode. AUTO_INC=1: WR_ADDR 0xFF, then two WR_DATA -> writes to 0xFF then 0x00.
- rst asserted on the 4th tx_valid cycle -> tx_valid, busy and tx_data read 0 in that same cycle. After release, a read with no new RD_ADDR gives cmd_err.
